lc3_mem_arb: RTL and testbench

LC3_MEM_ARB -- requirements
Module: lc3_mem_arb

---
 rtl/lc3_mem_arb.sv | 155 +++++++++++++++
 tb/tb_lc3_mem_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arb.sv
// Round-robin arbiter that serialises NUM_PORTS requesters onto one single-ported memory.
// Latency: grant on the IDLE sample, ack WAIT_STATES+2 cycles later; losers simply keep req high until served.
module lc3_mem_arb #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_PORTS     = 2,
    parameter int WAIT_STATES   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               req,
    input  logic [NUM_PORTS-1:0]               we,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_PORTS-1:0]               ack,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               busy,
    output logic [ADDRESS_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]              mem_data_in,
    output logic                               mem_write,
    input  logic [DATA_WIDTH-1:0]              mem_data_out
);

    localparam int              GW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [GW-1:0]   LP_LAST = GW'(NUM_PORTS - 1);
    localparam logic [GW:0]     LP_NP   = (GW + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [GW-1:0]              r_last_grant;
    logic [GW-1:0]              r_grant;
    logic [3:0]                 r_cnt;
    logic                       r_we;
    logic [ADDRESS_WIDTH-1:0]   r_mem_address;
    logic [DATA_WIDTH-1:0]      r_mem_data_in;
    logic [DATA_WIDTH-1:0]      r_rdata;

    logic                       w_grant_en;
    logic                       w_any;
    logic [GW-1:0]              w_start;
    logic [NUM_PORTS-1:0]       w_rot;
    logic [GW-1:0]              w_off;
    logic [GW:0]                w_sum;
    logic [GW-1:0]              w_gnt;
    logic [ADDRESS_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]      w_sel_wdata;
    logic                       w_sel_we;

    // Rotate the request vector so the search always begins at last_grant+1,
    // pick the lowest set bit, then rotate the offset back into a channel index.
    always_comb begin
        w_any   = |req;
        w_start = (r_last_grant == LP_LAST) ? '0 : r_last_grant + GW'(1);
        w_rot   = NUM_PORTS'({req, req} >> w_start);
        w_off   = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = GW'(j);
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        w_gnt = (w_sum >= LP_NP) ? GW'(w_sum - LP_NP) : w_sum[GW-1:0];
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt == GW'(i)) begin
                w_sel_addr  = addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_we    = we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        busy        = 1'b0;
        mem_write   = 1'b0;
        ack         = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ACCESS;
                    w_grant_en  = 1'b1;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_write = r_we && (r_cnt == '0);
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                w_state_nxt = IDLE;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    ack[i] = (r_grant == GW'(i));
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Channel inputs are captured only at grant; the memory sees these registers for the whole access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant  <= LP_LAST;
            r_grant       <= '0;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_rdata       <= '0;
        end else if (w_grant_en) begin
            r_last_grant  <= w_gnt;
            r_grant       <= w_gnt;
            r_cnt         <= 4'(WAIT_STATES);
            r_we          <= w_sel_we;
            r_mem_address <= w_sel_addr;
            r_mem_data_in <= w_sel_wdata;
        end else if (r_state == ACCESS) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (!r_we) begin
                r_rdata <= mem_data_out;
            end
        end
    end

    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign rdata       = r_rdata;

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Scoreboard bench for lc3_mem_arb: three instances (2 ports/1 wait, 4 ports/2 waits, 1 port/0 waits)
// driven with directed vectors; monitors pop expected acks and memory writes as the DUTs present them.
module tb_lc3_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t qa[$], wqa[$], qb[$], wqb[$], qc[$], wqc[$];

    logic [7:0] mem [256];

    // instance A: defaults
    logic        rst_a = 1'b0;
    logic [1:0]  req_a = '0, we_a = '0, ack_a;
    logic [15:0] addr_a = '0, wdata_a = '0;
    logic [7:0]  rdata_a, mem_address_a, mem_data_in_a, mdo_a;
    logic        busy_a, mem_write_a;
    assign mdo_a = mem[mem_address_a];

    // instance B: four ports, two wait states
    logic        rst_b = 1'b0;
    logic [3:0]  req_b = '0, we_b = '0, ack_b;
    logic [31:0] addr_b = '0, wdata_b = '0;
    logic [7:0]  rdata_b, mem_address_b, mem_data_in_b, mdo_b;
    logic        busy_b, mem_write_b;
    assign mdo_b = mem[mem_address_b];

    // instance C: one port, no wait states
    logic        rst_c = 1'b0;
    logic [0:0]  req_c = '0, we_c = '0, ack_c;
    logic [7:0]  addr_c = '0, wdata_c = '0;
    logic [7:0]  rdata_c, mem_address_c, mem_data_in_c, mdo_c;
    logic        busy_c, mem_write_c;
    assign mdo_c = mem[mem_address_c];

    lc3_mem_arb #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .NUM_PORTS(2), .WAIT_STATES(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .mem_address(mem_address_a),
        .mem_data_in(mem_data_in_a), .mem_write(mem_write_a), .mem_data_out(mdo_a)
    );

    lc3_mem_arb #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .NUM_PORTS(4), .WAIT_STATES(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .mem_address(mem_address_b),
        .mem_data_in(mem_data_in_b), .mem_write(mem_write_b), .mem_data_out(mdo_b)
    );

    lc3_mem_arb #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .NUM_PORTS(1), .WAIT_STATES(0)) u_dut_c (
        .clk(clk), .rst(rst_c), .req(req_c), .we(we_c), .addr(addr_c), .wdata(wdata_c),
        .ack(ack_c), .rdata(rdata_c), .busy(busy_c), .mem_address(mem_address_c),
        .mem_data_in(mem_data_in_c), .mem_write(mem_write_c), .mem_data_out(mdo_c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ack_a != '0) begin
            if (qa.size() == 0) chk("a_spurious_ack", 32'(ack_a), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_ack_chan", 32'(ack_a), 32'd1 << e.a);
                chk("a_rdata", 32'(rdata_a), e.d);
                chk("a_ack_cycle", cyc, e.c);
            end
        end
        if (mem_write_a) begin
            if (wqa.size() == 0) chk("a_spurious_write", 32'(mem_write_a), 32'd0);
            else begin
                e = wqa.pop_front();
                chk("a_wr_addr", 32'(mem_address_a), e.a);
                chk("a_wr_data", 32'(mem_data_in_a), e.d);
                chk("a_wr_cycle", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ack_b != '0) begin
            if (qb.size() == 0) chk("b_spurious_ack", 32'(ack_b), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_ack_chan", 32'(ack_b), 32'd1 << e.a);
                chk("b_rdata", 32'(rdata_b), e.d);
                chk("b_ack_cycle", cyc, e.c);
            end
        end
        if (mem_write_b) begin
            if (wqb.size() == 0) chk("b_spurious_write", 32'(mem_write_b), 32'd0);
            else begin
                e = wqb.pop_front();
                chk("b_wr_addr", 32'(mem_address_b), e.a);
                chk("b_wr_data", 32'(mem_data_in_b), e.d);
                chk("b_wr_cycle", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (ack_c != '0) begin
            if (qc.size() == 0) chk("c_spurious_ack", 32'(ack_c), 32'd0);
            else begin
                e = qc.pop_front();
                chk("c_ack_chan", 32'(ack_c), 32'd1 << e.a);
                chk("c_rdata", 32'(rdata_c), e.d);
                chk("c_ack_cycle", cyc, e.c);
            end
        end
        if (mem_write_c) begin
            if (wqc.size() == 0) chk("c_spurious_write", 32'(mem_write_c), 32'd0);
            else begin
                e = wqc.pop_front();
                chk("c_wr_addr", 32'(mem_address_c), e.a);
                chk("c_wr_data", 32'(mem_data_in_c), e.d);
                chk("c_wr_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h12] = 8'hA5;
        mem[8'h34] = 8'h77;

        tick(3);
        chk("a_rst_ack", 32'(ack_a), 32'd0);
        chk("a_rst_busy", 32'(busy_a), 32'd0);
        chk("a_rst_mem_write", 32'(mem_write_a), 32'd0);
        chk("a_rst_mem_address", 32'(mem_address_a), 32'd0);
        chk("a_rst_mem_data_in", 32'(mem_data_in_a), 32'd0);
        chk("a_rst_rdata", 32'(rdata_a), 32'd0);
        chk("b_rst_busy", 32'(busy_b), 32'd0);
        chk("c_rst_busy", 32'(busy_c), 32'd0);
        rst_a = 1'b1;

        // A: single read of 0x12, req dropped right after grant
        t = cyc;
        req_a = 2'b01; we_a = 2'b00; addr_a = {8'h00, 8'h12};
        qa.push_back('{0, 32'hA5, t + 3});
        tick(1);
        req_a = 2'b00;
        chk("a_busy_access", 32'(busy_a), 32'd1);
        chk("a_addr_access", 32'(mem_address_a), 32'h12);
        tick(4);

        // A: address changes one cycle after grant; access must still use 0x12
        t = cyc;
        req_a = 2'b01; addr_a = {8'h00, 8'h12};
        qa.push_back('{0, 32'hA5, t + 3});
        tick(1);
        req_a = 2'b00; addr_a = {8'h00, 8'h34};
        tick(1);
        chk("a_addr_latched", 32'(mem_address_a), 32'h12);
        tick(3);

        // A: both request; ch1 wins (last grant was 0), ch0 held and writes next, rdata kept
        t = cyc;
        req_a = 2'b11; we_a = 2'b01; addr_a = {8'h20, 8'h21}; wdata_a = {8'h00, 8'h99};
        qa.push_back('{1, 32'h7A, t + 3});
        qa.push_back('{0, 32'h7A, t + 7});
        wqa.push_back('{32'h21, 32'h99, t + 6});
        tick(5);
        req_a = 2'b00; we_a = 2'b00;
        tick(4);

        // A: reset during ACCESS aborts the transaction
        req_a = 2'b10; addr_a = {8'h30, 8'h21};
        tick(1);
        req_a = 2'b00; rst_a = 1'b0;
        tick(1);
        chk("a_abort_busy", 32'(busy_a), 32'd0);
        chk("a_abort_mem_write", 32'(mem_write_a), 32'd0);
        chk("a_abort_ack", 32'(ack_a), 32'd0);
        chk("a_abort_mem_address", 32'(mem_address_a), 32'd0);
        chk("a_abort_rdata", 32'(rdata_a), 32'd0);
        rst_a = 1'b1;
        tick(2);

        // A: after reset channel 0 has first priority
        t = cyc;
        req_a = 2'b11; addr_a = {8'h20, 8'h12};
        qa.push_back('{0, 32'hA5, t + 3});
        qa.push_back('{1, 32'h7A, t + 7});
        tick(5);
        req_a = 2'b00;
        tick(4);

        // B: all four request from reset -> 0,1,2,3,0 every WAIT_STATES+3 cycles
        req_b = 4'hF; we_b = 4'h0; addr_b = {8'h53, 8'h52, 8'h51, 8'h50};
        tick(1);
        t = cyc;
        rst_b = 1'b1;
        qb.push_back('{0, 32'h0A, t + 4});
        qb.push_back('{1, 32'h0B, t + 9});
        qb.push_back('{2, 32'h08, t + 14});
        qb.push_back('{3, 32'h09, t + 19});
        qb.push_back('{0, 32'h0A, t + 24});
        tick(21);
        req_b = 4'h0;
        tick(5);

        // B: ch1 writes 0x3C to 0x40; rdata keeps the last read value
        t = cyc;
        req_b = 4'b0010; we_b = 4'b0010;
        addr_b = {8'h53, 8'h52, 8'h40, 8'h50}; wdata_b = {8'h00, 8'h00, 8'h3C, 8'h00};
        qb.push_back('{1, 32'h0A, t + 4});
        wqb.push_back('{32'h40, 32'h3C, t + 3});
        tick(1);
        req_b = 4'h0; we_b = 4'h0;
        tick(5);

        // C: single port, zero wait states
        rst_c = 1'b1;
        tick(1);
        t = cyc;
        req_c = 1'b1; we_c = 1'b0; addr_c = 8'h12;
        qc.push_back('{0, 32'hA5, t + 2});
        tick(1);
        req_c = 1'b0;
        tick(3);

        t = cyc;
        req_c = 1'b1; we_c = 1'b1; addr_c = 8'h60; wdata_c = 8'h5E;
        qc.push_back('{0, 32'hA5, t + 2});
        wqc.push_back('{32'h60, 32'h5E, t + 1});
        tick(1);
        req_c = 1'b0; we_c = 1'b0;
        tick(3);

        // C: held request is re-granted every 3 cycles
        t = cyc;
        req_c = 1'b1; addr_c = 8'h20;
        qc.push_back('{0, 32'h7A, t + 2});
        qc.push_back('{0, 32'h7A, t + 5});
        tick(4);
        req_c = 1'b0;
        tick(4);

        chk("a_pending_acks", qa.size(), 32'd0);
        chk("a_pending_writes", wqa.size(), 32'd0);
        chk("b_pending_acks", qb.size(), 32'd0);
        chk("b_pending_writes", wqb.size(), 32'd0);
        chk("c_pending_acks", qc.size(), 32'd0);
        chk("c_pending_writes", wqc.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
